// File: rtl/alu_cmd_sequencer.sv
// Valid/ready command sequencer wrapped around the 3-bit combinational ALU.
// Registers operands, captures result/flags, keeps accumulator and op count.
module alu_cmd_sequencer #(
  parameter int         CNT_W   = 8,
  parameter logic [2:0] ACC_RST = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_a,
  input  logic [2:0]       cmd_b,
  input  logic             cmd_use_acc,
  input  logic             acc_clear,
  output logic [2:0]       alu_a,
  output logic [2:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [2:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_equal,
  input  logic             alu_lt,
  input  logic             alu_gt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [2:0]       acc,
  output logic             carry_sticky,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       alu_a_q, alu_a_d;
  logic [2:0]       alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic [2:0]       rsp_result_q, rsp_result_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;
  logic [2:0]       acc_q, acc_d;
  logic             carry_sticky_q, carry_sticky_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      alu_a_q        <= 3'b000;
      alu_b_q        <= 3'b000;
      alu_sel_q      <= 3'b000;
      rsp_result_q   <= 3'b000;
      rsp_flags_q    <= 5'b00000;
      acc_q          <= ACC_RST;
      carry_sticky_q <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_sel_q      <= alu_sel_d;
      rsp_result_q   <= rsp_result_d;
      rsp_flags_q    <= rsp_flags_d;
      acc_q          <= acc_d;
      carry_sticky_q <= carry_sticky_d;
      op_count_q     <= op_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_sel_d      = alu_sel_q;
    rsp_result_d   = rsp_result_q;
    rsp_flags_d    = rsp_flags_q;
    acc_d          = acc_q;
    carry_sticky_d = carry_sticky_q;
    op_count_d     = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d   = cmd_use_acc ? acc_q : cmd_a;
          alu_b_d   = cmd_b;
          alu_sel_d = cmd_op;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = {alu_gt, alu_lt, alu_equal,
                        alu_zero, alu_carry};
        // compare ops (101..111) do not touch acc
        if (alu_sel_q <= 3'b100) acc_d = alu_result;
        if (alu_carry) carry_sticky_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // clear overrides any same-cycle accumulator write
    if (acc_clear) begin
      acc_d          = ACC_RST;
      carry_sticky_d = 1'b0;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_flags    = rsp_flags_q;
  assign acc          = acc_q;
  assign carry_sticky = carry_sticky_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU stand-in
// and a result scoreboard.
module tb_alu_cmd_sequencer;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_a;
  logic [2:0]       cmd_b;
  logic             cmd_use_acc;
  logic             acc_clear;
  logic [2:0]       alu_a;
  logic [2:0]       alu_b;
  logic [2:0]       alu_sel;
  logic [2:0]       alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_equal;
  logic             alu_lt;
  logic             alu_gt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_result;
  logic [4:0]       rsp_flags;
  logic [2:0]       acc;
  logic             carry_sticky;
  logic [CNT_W-1:0] op_count;
  logic             busy;

  alu_cmd_sequencer #(.CNT_W(CNT_W), .ACC_RST(3'b000)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc), .acc_clear(acc_clear),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_equal(alu_equal),
    .alu_lt(alu_lt), .alu_gt(alu_gt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .acc(acc), .carry_sticky(carry_sticky),
    .op_count(op_count), .busy(busy)
  );

  // {gt, lt, equal, zero, carry, result[2:0]}
  function automatic logic [7:0] alu_fn(input logic [2:0] op,
                                        input logic [2:0] a,
                                        input logic [2:0] b);
    logic [3:0] s;
    logic [2:0] r;
    logic c, z, eq, lt, gt;
    c = 0; z = 0; eq = 0; lt = 0; gt = 0; r = 0;
    case (op)
      3'd0: begin r = a ^ b; z = (r == 0); end
      3'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[2:0]; c = s[3]; end
      3'd2: begin r = a - b; c = (a < b); end
      3'd3: begin r = a & b; z = (r == 0); end
      3'd4: begin r = a | b; z = (r == 0); end
      3'd5: begin eq = (a == b); r = {2'b00, eq}; end
      3'd6: begin lt = (a < b); r = {2'b00, lt}; end
      default: begin gt = (a > b); r = {2'b00, gt}; end
    endcase
    return {gt, lt, eq, z, c, r};
  endfunction

  logic [7:0] alu_o;
  assign alu_o      = alu_fn(alu_sel, alu_a, alu_b);
  assign alu_result = alu_o[2:0];
  assign alu_carry  = alu_o[3];
  assign alu_zero   = alu_o[4];
  assign alu_equal  = alu_o[5];
  assign alu_lt     = alu_o[6];
  assign alu_gt     = alu_o[7];

  initial clk = 0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb_q[$];
  logic [2:0] acc_m;
  logic       stk_m;
  int         cnt_m;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic ua,
                         input logic clr_acc, input logic clr_exec,
                         input int hold);
    logic [2:0] opa;
    logic [7:0] e, got;
    int n;
    chk("idle_ready", {7'd0, cmd_ready}, 8'd1);
    opa = ua ? acc_m : a;
    e = alu_fn(op, opa, b);
    sb_q.push_back(e);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    cmd_valid = 1; acc_clear = clr_acc;
    @(negedge clk);
    cmd_valid = 0; acc_clear = clr_exec; cmd_a = ~a; cmd_b = ~b;
    chk("exec_alu_a", {5'd0, alu_a}, {5'd0, opa});
    chk("exec_alu_b", {5'd0, alu_b}, {5'd0, b});
    chk("exec_alu_sel", {5'd0, alu_sel}, {5'd0, op});
    chk("exec_busy", {6'd0, busy, cmd_ready}, 8'd2);
    chk("exec_no_rsp", {7'd0, rsp_valid}, 8'd0);
    if (clr_acc) begin acc_m = 3'b000; stk_m = 0; end
    if (clr_exec) begin
      acc_m = 3'b000; stk_m = 0;
    end else begin
      if (op <= 3'b100) acc_m = e[2:0];
      if (e[3]) stk_m = 1;
    end
    @(negedge clk);
    acc_clear = 0;
    n = 0;
    while (!rsp_valid && n < 4) begin @(negedge clk); n++; end
    chk("rsp_latency", n[7:0], 8'd0);
    got = {rsp_flags, rsp_result};
    if (sb_q.size() > 0) e = sb_q.pop_front();
    chk("rsp_data", got, e);
    chk("rsp_no_ready", {7'd0, cmd_ready}, 8'd0);
    if (hold > 0) begin
      rsp_ready = 0;
      cmd_valid = 1; cmd_use_acc = 0; cmd_op = 3'd3;
      repeat (hold) begin
        @(negedge clk);
        chk("bp_valid", {7'd0, rsp_valid}, 8'd1);
        chk("bp_stable", {rsp_flags, rsp_result}, e);
        chk("bp_no_ready", {7'd0, cmd_ready}, 8'd0);
      end
      cmd_valid = 0;
      rsp_ready = 1;
    end
    cnt_m = (cnt_m + 1) % (1 << CNT_W);
    @(negedge clk);
    chk("done_idle", {5'd0, cmd_ready, busy, rsp_valid}, 8'd4);
    chk("done_count", {6'd0, op_count}, cnt_m[7:0]);
    chk("done_acc", {5'd0, acc}, {5'd0, acc_m});
    chk("done_sticky", {7'd0, carry_sticky}, {7'd0, stk_m});
    chk("done_hold_b", {5'd0, alu_b}, {5'd0, b});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0;
    cmd_use_acc = 0; acc_clear = 0; rsp_ready = 1;
    acc_m = 3'b000; stk_m = 0; cnt_m = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {5'd0, cmd_ready, busy, rsp_valid}, 8'd4);
    chk("rst_alu", {alu_sel, alu_b, alu_a[1:0]}, 8'd0);
    chk("rst_rsp", {rsp_flags, rsp_result}, 8'd0);
    chk("rst_acc", {2'd0, op_count, carry_sticky, acc}, 8'd0);
    rst_n = 1;
    @(negedge clk);

    run_cmd(3'd1, 3'd5, 3'd3, 0, 0, 0, 0);
    chk("add_res", {rsp_flags, rsp_result}, 8'b00001_000);
    chk("add_sticky", {7'd0, carry_sticky}, 8'd1);
    chk("add_count", {6'd0, op_count}, 8'd1);

    run_cmd(3'd2, 3'd2, 3'd5, 0, 0, 0, 0);
    chk("sub_res", {7'd0, rsp_flags[0]}, 8'd1);
    chk("sub_val", {5'd0, rsp_result}, 8'd5);
    run_cmd(3'd6, 3'd2, 3'd5, 0, 0, 0, 0);
    chk("lt_flag", {7'd0, rsp_flags[3]}, 8'd1);
    chk("lt_acc", {5'd0, acc}, 8'd5);

    run_cmd(3'd0, 3'd6, 3'd6, 0, 0, 0, 0);
    chk("xor_zero", {7'd0, rsp_flags[1]}, 8'd1);
    run_cmd(3'd4, 3'd7, 3'd4, 1, 0, 0, 0);
    chk("or_chain", {2'd0, alu_a, acc}, 8'b00_000_100);

    run_cmd(3'd1, 3'd1, 3'd1, 0, 0, 0, 5);

    run_cmd(3'd1, 3'd3, 3'd2, 0, 0, 1, 0);
    chk("clr_exec", {3'd0, carry_sticky, rsp_result, acc[0]},
        8'b000_0_101_0);
    chk("clr_acc", {5'd0, acc}, 8'd0);

    run_cmd(3'd1, 3'd1, 3'd2, 0, 0, 0, 0);
    run_cmd(3'd1, 3'd0, 3'd1, 1, 1, 0, 0);
    chk("clr_accept", {2'd0, alu_a, acc}, 8'b00_011_100);

    cmd_op = 3'd1; cmd_a = 3'd7; cmd_b = 3'd7; cmd_use_acc = 0;
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("pre_rst_busy", {7'd0, busy}, 8'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_ctrl", {5'd0, cmd_ready, busy, rsp_valid}, 8'd4);
    chk("mid_rst_alu", {alu_sel, alu_b, alu_a[1:0]}, 8'd0);
    chk("mid_rst_state", {2'd0, op_count, carry_sticky, acc}, 8'd0);
    acc_m = 3'b000; stk_m = 0; cnt_m = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_norsp", {6'd0, rsp_valid, op_count[0]}, 8'd0);
    end

    run_cmd(3'd3, 3'd6, 3'd3, 0, 0, 0, 0);
    run_cmd(3'd7, 3'd6, 3'd3, 0, 0, 0, 0);
    run_cmd(3'd5, 3'd4, 3'd4, 0, 0, 0, 0);
    chk("pre_wrap", {6'd0, op_count}, 8'd3);
    run_cmd(3'd1, 3'd4, 3'd4, 0, 0, 0, 0);
    chk("wrap", {6'd0, op_count}, 8'd0);
    chk("sb_empty", sb_q.size(), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
